// File: rtl/ef_spi_mc.sv
// rtl/ef_spi_mc.sv - FIFO-buffered SPI master with programmable frame length, bit order and chip selects
// Optional feature macro: EF_SPI_MC_LOOPBACK_EN (adds the loopback input; sampler takes mosi when set)

module ef_spi_mc_fifo #(
  parameter int DW  = 8,
  parameter int FAW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [FAW:0]  level,
  output logic          empty,
  output logic          full
);
  logic [DW-1:0]  mem [2**FAW];
  logic [FAW-1:0] wp, rp;
  logic           push_ok, pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == {1'b1, {FAW{1'b0}}});
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rp];

  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wp] <= wdata;
  end

  // pointers and occupancy; flush overrides any same-cycle push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (pop_ok && !push_ok) level <= level - 1'b1;
    end
  end
endmodule

module ef_spi_mc #(
  parameter  int DW  = 8,
  parameter  int CDW = 8,
  parameter  int FAW = 4,
  parameter  int NCS = 2,
  localparam int LW  = $clog2(DW) + 1,
  localparam int CSW = $clog2(NCS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           lsb_first,
  input  logic [LW-1:0]  frame_len,
  input  logic [CDW-1:0] clk_divider,
  input  logic [CSW-1:0] cs_sel,
  input  logic           cs_hold,
  input  logic           wr,
  input  logic [DW-1:0]  datai,
  input  logic           rd,
  output logic [DW-1:0]  datao,
  input  logic           rx_en,
  input  logic           tx_flush,
  input  logic           rx_flush,
  input  logic [FAW:0]   tx_threshold,
  input  logic [FAW:0]   rx_threshold,
  output logic           tx_empty,
  output logic           tx_full,
  output logic           tx_level_below,
  output logic [FAW:0]   tx_level,
  output logic           rx_empty,
  output logic           rx_full,
  output logic           rx_level_above,
  output logic [FAW:0]   rx_level,
  output logic           rx_ovf,
  output logic           busy,
`ifdef EF_SPI_MC_LOOPBACK_EN
  input  logic           loopback,
`endif
  input  logic           miso,
  output logic           mosi,
  output logic           sclk,
  output logic [NCS-1:0] csb
);
  localparam int IW = $clog2(DW);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t         state;
  logic [CDW-1:0] cnt, div_s;
  logic           cpol_s, cpha_s, lsb_s, hold_s;
  logic [LW-1:0]  n_s, idx, len_in;
  logic [LW:0]    ecnt;
  logic [DW-1:0]  word_s, rx_sh, rx_word, tx_head;
  logic           rx_push, tick, start_idle, chain, tx_pop, sin;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] fl);
    if (fl == '0 || fl > LW'(DW)) return LW'(DW);
    return fl;
  endfunction

  // wire position of the i-th bit on the line for the active bit order
  function automatic logic [IW-1:0] bit_pos(input logic [LW-1:0] i, input logic [LW-1:0] n,
                                            input logic lsb);
    logic [LW-1:0] p;
    p = lsb ? i : n - i - 1'b1;
    return p[IW-1:0];
  endfunction

  function automatic logic [NCS-1:0] csb_dec(input logic [CSW-1:0] s);
    logic [NCS-1:0] v;
    v = '1;
    for (int i = 0; i < NCS; i++) if (int'(s) == i) v[i] = 1'b0;
    return v;
  endfunction

`ifdef EF_SPI_MC_LOOPBACK_EN
  assign sin = loopback ? mosi : miso;
`else
  assign sin = miso;
`endif

  assign tick       = (cnt == '0);
  assign len_in     = eff_len(frame_len);
  assign start_idle = (state == S_IDLE) && enable && !tx_empty && !tx_flush;
  assign chain      = (state == S_HOLD) && tick && hold_s && enable && !tx_empty && !tx_flush;
  assign tx_pop     = start_idle || chain;

  assign tx_level_below = (tx_level < tx_threshold);
  assign rx_level_above = (rx_level > rx_threshold);

  ef_spi_mc_fifo #(.DW(DW), .FAW(FAW)) u_tx (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(wr), .wdata(datai), .pop(tx_pop),
    .rdata(tx_head), .level(tx_level), .empty(tx_empty), .full(tx_full)
  );

  ef_spi_mc_fifo #(.DW(DW), .FAW(FAW)) u_rx (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .wdata(rx_word), .pop(rd),
    .rdata(datao), .level(rx_level), .empty(rx_empty), .full(rx_full)
  );

  // overrun flag: a completed frame arrives while the RX FIFO is full and not being drained
  always_ff @(posedge clk) begin
    if (rst) rx_ovf <= 1'b0;
    else     rx_ovf <= rx_push && rx_full && !rd && !rx_flush;
  end

  // frame sequencer: every state step lasts one half period, config latched at each frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_s   <= '0;
      cpol_s  <= 1'b0;
      cpha_s  <= 1'b0;
      lsb_s   <= 1'b0;
      hold_s  <= 1'b0;
      n_s     <= '0;
      idx     <= '0;
      ecnt    <= '0;
      word_s  <= '0;
      rx_sh   <= '0;
      rx_word <= '0;
      rx_push <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      csb     <= '1;
      busy    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      if (!tick) cnt <= cnt - 1'b1;
      case (state)
        S_IDLE: begin
          sclk <= cpol;
          csb  <= '1;
          busy <= 1'b0;
        end
        S_SETUP: if (tick) begin
          state <= S_XFER;
          cnt   <= div_s;
          ecnt  <= '0;
          idx   <= '0;
        end
        S_XFER: if (tick) begin
          cnt  <= div_s;
          sclk <= ~sclk;
          if (!ecnt[0]) begin
            if (cpha_s) mosi <= word_s[bit_pos(idx, n_s, lsb_s)];
            else        rx_sh[bit_pos(idx, n_s, lsb_s)] <= sin;
          end else begin
            if (cpha_s)                  rx_sh[bit_pos(idx, n_s, lsb_s)] <= sin;
            else if (idx + 1'b1 < n_s)   mosi <= word_s[bit_pos(idx + 1'b1, n_s, lsb_s)];
            idx <= idx + 1'b1;
          end
          if (ecnt == {n_s, 1'b0} - 1'b1) state <= S_HOLD;
          else                            ecnt  <= ecnt + 1'b1;
        end
        S_HOLD: if (tick) begin
          rx_push <= rx_en;
          rx_word <= rx_sh;
          cnt     <= div_s;
          if (!chain) begin
            state <= S_GAP;
            csb   <= '1;
          end
        end
        S_GAP: if (tick) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (tx_pop) begin
        state  <= S_SETUP;
        busy   <= 1'b1;
        cnt    <= clk_divider;
        div_s  <= clk_divider;
        cpol_s <= cpol;
        cpha_s <= cpha;
        lsb_s  <= lsb_first;
        hold_s <= cs_hold;
        n_s    <= len_in;
        word_s <= tx_head;
        rx_sh  <= '0;
        sclk   <= cpol;
        if (start_idle) csb <= csb_dec(cs_sel);
        if (!cpha) mosi <= tx_head[bit_pos(LW'(0), len_in, lsb_first)];
      end
    end
  end
endmodule

// File: tb/tb_ef_spi_mc.sv
// tb/tb_ef_spi_mc.sv - directed scoreboard bench for ef_spi_mc
module tb_ef_spi_mc;
  localparam int DW = 8, CDW = 8, FAW = 4, NCS = 2, LW = 4, CSW = 1;

  logic clk = 0, rst = 1, enable = 0, cpol = 0, cpha = 0, lsb_first = 0, cs_hold = 0;
  logic [LW-1:0]  frame_len = 8;
  logic [CDW-1:0] clk_divider = 1;
  logic [CSW-1:0] cs_sel = 0;
  logic wr = 0, rd = 0, rx_en = 1, tx_flush = 0, rx_flush = 0;
  logic [DW-1:0]  datai = 0, datao;
  logic [FAW:0]   tx_threshold = 4, rx_threshold = 8, tx_level, rx_level;
  logic tx_empty, tx_full, tx_level_below, rx_empty, rx_full, rx_level_above, rx_ovf, busy;
  logic miso, mosi, sclk;
  logic [NCS-1:0] csb;
  logic loop_ext = 1, miso_val = 0;
`ifdef EF_SPI_MC_LOOPBACK_EN
  logic loopback = 0;
`endif

  assign miso = loop_ext ? mosi : miso_val;

  ef_spi_mc #(.DW(DW), .CDW(CDW), .FAW(FAW), .NCS(NCS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .frame_len(frame_len), .clk_divider(clk_divider), .cs_sel(cs_sel), .cs_hold(cs_hold),
    .wr(wr), .datai(datai), .rd(rd), .datao(datao), .rx_en(rx_en),
    .tx_flush(tx_flush), .rx_flush(rx_flush), .tx_threshold(tx_threshold), .rx_threshold(rx_threshold),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_level_below(tx_level_below), .tx_level(tx_level),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_level_above(rx_level_above), .rx_level(rx_level),
    .rx_ovf(rx_ovf), .busy(busy),
`ifdef EF_SPI_MC_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso), .mosi(mosi), .sclk(sclk), .csb(csb)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // line monitor: mosi at every rising sclk while a CS is low, CS activity, overrun pulses
  logic cap[$];
  logic sclk_q = 0, csb1_q = 1;
  int   cs0_low = 0, cs1_rise = 0, hi_run = 0, min_gap1 = 1000, ovf_cnt = 0;
  bit   seen_low1 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (csb != '1 && sclk && !sclk_q) cap.push_back(mosi);
      if (!csb[0]) cs0_low++;
      if (csb[1] && !csb1_q) cs1_rise++;
      if (csb[1]) hi_run++;
      else begin
        if (seen_low1 && hi_run > 0 && hi_run < min_gap1) min_gap1 = hi_run;
        hi_run = 0;
        seen_low1 = 1;
      end
      if (rx_ovf) ovf_cnt++;
    end
    sclk_q = sclk;
    csb1_q = csb[1];
  end

  function automatic logic [31:0] cap_val(input int from, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], cap[from+i]};
    return v;
  endfunction

  task automatic push(input logic [DW-1:0] w, input bit expect_rx, input logic [DW-1:0] exp);
    @(negedge clk);
    wr = 1;
    datai = w;
    if (expect_rx) sb.push_back(exp);
  endtask

  task automatic push_done();
    @(negedge clk);
    wr = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy || !tx_empty) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rx(input string tag);
    int n;
    logic [DW-1:0] exp;
    n = 0;
    while (rx_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    chk({tag, "_avail"}, {31'd0, rx_empty}, 32'd0);
    chk(tag, {24'd0, datao}, {24'd0, exp});
    rd = 1;
    @(negedge clk);
    rd = 0;
  endtask

  initial begin
    int b, c0, r1, o, n;
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c0, r1, o, n;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_csb", {30'd0, csb}, 32'd3);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, rx_ovf}, 32'd0);
    chk("rst_datao", {24'd0, datao}, 32'd0);
    chk("rst_txlvl", {27'd0, tx_level}, 32'd0);
    chk("rst_rxlvl", {27'd0, rx_level}, 32'd0);
    chk("rst_txempty", {31'd0, tx_empty}, 32'd1);
    chk("rst_txfull", {31'd0, tx_full}, 32'd0);
    chk("rst_rxempty", {31'd0, rx_empty}, 32'd1);
    chk("rst_rxfull", {31'd0, rx_full}, 32'd0);
    chk("rst_txbelow", {31'd0, tx_level_below}, 32'd1);
    chk("rst_rxabove", {31'd0, rx_level_above}, 32'd0);
    rst = 0;
    enable = 1;
    repeat (2) @(negedge clk);

    // mode 0, 8 bits MSB first, external loop
    b = cap.size();
    c0 = cs0_low;
    push(8'hA5, 1, 8'hA5);
    push_done();
    wait_idle("t1_idle", 400);
    chk("t1_nbits", cap.size() - b, 8);
    chk("t1_mosi", cap_val(b, 8), 32'hA5);
    chk("t1_cs_low", cs0_low - c0, 36);
    check_rx("t1_rx");

    // mode 3, 5 bits LSB first, miso held high
    cpol = 1; cpha = 1; lsb_first = 1; frame_len = 5; loop_ext = 0; miso_val = 1;
    repeat (3) @(negedge clk);
    b = cap.size();
    c0 = cs0_low;
    push(8'h13, 1, 8'h1F);
    push_done();
    wait_idle("t2_idle", 400);
    chk("t2_nbits", cap.size() - b, 5);
    chk("t2_mosi", cap_val(b, 5), 32'h19);
    chk("t2_cs_low", cs0_low - c0, 24);
    check_rx("t2_rx");

    // CS hold across three frames on cs 1
    cpol = 0; cpha = 0; lsb_first = 0; frame_len = 8; loop_ext = 1; cs_sel = 1; cs_hold = 1;
    repeat (3) @(negedge clk);
    b = cap.size();
    c0 = cs0_low;
    r1 = cs1_rise;
    push(8'h3C, 1, 8'h3C);
    push(8'h81, 1, 8'h81);
    push(8'h7E, 1, 8'h7E);
    push_done();
    wait_idle("t3_idle", 1000);
    chk("t3_nbits", cap.size() - b, 24);
    chk("t3_mosi", cap_val(b, 24), 32'h3C817E);
    chk("t3_cs1_rises", cs1_rise - r1, 1);
    chk("t3_cs0_low", cs0_low - c0, 0);
    for (int i = 0; i < 3; i++) check_rx("t3_rx");

    // without hold every frame releases CS for at least H
    cs_hold = 0;
    r1 = cs1_rise;
    push(8'h5A, 1, 8'h5A);
    push(8'hC3, 1, 8'hC3);
    push_done();
    wait_idle("t3b_idle", 1000);
    chk("t3b_cs1_rises", cs1_rise - r1, 2);
    chk("t3b_gap_ge_h", {31'd0, min_gap1 >= 2}, 32'd1);
    for (int i = 0; i < 2; i++) check_rx("t3b_rx");

    // RX overrun on a full FIFO
    cs_sel = 0; clk_divider = 0;
    for (int i = 0; i < 16; i++) push(8'(i * 17 + 3), 1, 8'(i * 17 + 3));
    push_done();
    wait_idle("t4_idle", 2000);
    repeat (3) @(negedge clk);
    chk("t4_rxlvl16", {27'd0, rx_level}, 32'd16);
    chk("t4_rxfull", {31'd0, rx_full}, 32'd1);
    chk("t4_rxabove", {31'd0, rx_level_above}, 32'd1);
    o = ovf_cnt;
    push(8'hEE, 0, 8'h00);
    push_done();
    wait_idle("t4b_idle", 400);
    repeat (3) @(negedge clk);
    chk("t4_ovf_pulses", ovf_cnt - o, 1);
    chk("t4_rxlvl_kept", {27'd0, rx_level}, 32'd16);
    chk("t4_head_kept", {24'd0, datao}, {24'd0, sb[0]});
    for (int i = 0; i < 16; i++) check_rx("t4_drain");

    // push and flush in the same cycle
    enable = 0;
    push(8'h77, 0, 8'h00);
    push_done();
    chk("t5_lvl1", {27'd0, tx_level}, 32'd1);
    @(negedge clk);
    wr = 1; datai = 8'h66; tx_flush = 1;
    @(negedge clk);
    wr = 0; tx_flush = 0;
    chk("t5_flush_lvl", {27'd0, tx_level}, 32'd0);
    chk("t5_flush_empty", {31'd0, tx_empty}, 32'd1);
    enable = 1;
    clk_divider = 1;

    // reset in the middle of a frame
    push(8'h11, 1, 8'h11);
    push(8'h22, 1, 8'h22);
    push(8'h33, 1, 8'h33);
    push_done();
    n = 0;
    while (rx_level != 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_rx", {27'd0, rx_level}, 32'd1);
    repeat (10) @(negedge clk);
    chk("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk("t6_csb", {30'd0, csb}, 32'd3);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_txlvl", {27'd0, tx_level}, 32'd0);
    chk("t6_rxlvl", {27'd0, rx_level}, 32'd0);
    rst = 0;
    sb.delete();
    repeat (2) @(negedge clk);

`ifdef EF_SPI_MC_LOOPBACK_EN
    // internal loopback ignores miso
    loopback = 1; loop_ext = 0; miso_val = 0;
    push(8'h3C, 1, 8'h3C);
    push_done();
    wait_idle("t7_idle", 400);
    check_rx("t7_rx");
    loopback = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ef_spi_mc.md
# ef_spi_mc

Parametrised SPI master, next generation of the team's FIFO-buffered SPI block. Adds programmable frame length up to `DW` bits, LSB/MSB-first ordering, `NCS` hardware-driven chip selects with optional CS hold across back-to-back frames, and RX overrun reporting. TX/RX FIFOs are internal. Sits between the bus-register wrapper (which drives the config ports and FIFO strobes) and the chip pins.

## Interface
- `DW`, 8: max frame width in bits (≥2); `LW = $clog2(DW)+1`.
- `CDW`, 8: clock-divider width.
- `FAW`, 4: FIFO address width; depth `2**FAW`.
- `NCS`, 2: number of chip selects (≥2); `CSW = $clog2(NCS)`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: allows new frames to start.
- `cpol`, `cpha` in 1 each: SPI mode.
- `lsb_first` in 1: 1 = bit 0 first.
- `frame_len` in LW: bits per frame, 1..DW; 0 or >DW means DW.
- `clk_divider` in CDW: half sclk period = `clk_divider+1` clk cycles.
- `cs_sel` in CSW: chip select to drive; ≥NCS means none asserted.
- `cs_hold` in 1: keep CS low between consecutive frames.
- `wr` in 1, `datai` in DW: TX FIFO push, right-justified.
- `rd` in 1, `datao` out DW: RX FIFO pop; `datao` is head (show-ahead), right-justified, upper bits 0.
- `rx_en` in 1: store received frames.
- `tx_flush`, `rx_flush` in 1: clear FIFO.
- `tx_threshold`, `rx_threshold` in FAW+1.
- `tx_empty`, `tx_full`, `tx_level_below`, `tx_level`[FAW+1] out.
- `rx_empty`, `rx_full`, `rx_level_above`, `rx_level`[FAW+1] out.
- `rx_ovf` out 1: one-cycle pulse when a received frame is dropped on full RX FIFO.
- `busy` out 1: state ≠ IDLE.
- `miso` in 1; `mosi` out 1; `sclk` out 1; `csb` out NCS, active-low.

## Operation
- States: IDLE, SETUP, XFER, HOLD, GAP. Every state step is one half period H = `clk_divider+1` cycles.
- IDLE: `sclk`=`cpol`, `csb` all 1. If `enable` & !`tx_empty`: pop TX, latch `cpol/cpha/lsb_first/frame_len/cs_sel/clk_divider/cs_hold` into shadow regs, go SETUP.
- SETUP (H): selected `csb` low; CPHA=0 drives first bit on `mosi` at entry.
- XFER: 2·N sclk edges, one per H (N = effective frame length). CPHA=0: sample `miso` on leading edge, shift `mosi` on trailing edge. CPHA=1: shift on leading edge (first bit driven there), sample on trailing edge.
- HOLD (H): `sclk` at idle level. At exit: if `rx_en`, push RX word; if RX full, word dropped and `rx_ovf` pulses. Then if shadow `cs_hold` & `enable` & !`tx_empty`: pop, relatch config (except `cs_sel`, which is held), go SETUP with CS still low. Otherwise go GAP.
- GAP (H): `csb` all 1, then IDLE.
- `enable` deasserted mid-frame: current frame completes normally, no new frame starts.
- Config port changes mid-frame have no effect until the next latch.
- FIFOs: push on full and pop on empty are ignored. Simultaneous push+pop: both take effect, level unchanged. Flush wins over same-cycle push/pop. Level is FAW+1 bits, 0..2**FAW. `tx_level_below` = `tx_level < tx_threshold`; `rx_level_above` = `rx_level > rx_threshold`.

## Timing
- Reset values: state IDLE, `csb` all 1, `sclk` 0 (follows `cpol` from the first cycle after reset), `mosi` 0, `busy` 0, `rx_ovf` 0, `datao` 0, levels 0, `*_empty` 1, `*_full` 0, `tx_level_below` = (0 < `tx_threshold`), `rx_level_above` 0.
- Reset mid-frame aborts at once. `csb` returns to 1 on the next clock edge and both FIFOs are emptied.
- `wr` to TX not empty: 1 cycle. IDLE to `csb` low: 1 cycle after `tx_empty` falls.
- Frame duration (CS low to CS high, single frame): (2N+2)·H cycles. Minimum CS-high gap: H.
- RX push visible on `rx_level`/`datao` 1 cycle after HOLD exit.
- All outputs are registered, except `datao`, the FIFO flags and the threshold compares.

## Configuration
- `EF_SPI_MC_LOOPBACK_EN`: when defined, adds input port `loopback` (1 bit). When it is 1, the receive sampler takes the internal `mosi` instead of `miso`, and `miso` is ignored.
- When the macro is undefined, the port is absent and the sampler always uses `miso`.

## Test plan
- Mode 0, `frame_len`=8, MSB-first, `clk_divider`=1, push 0xA5, `miso` tied to `mosi` externally -> `mosi` bits 1,0,1,0,0,1,0,1. `csb[0]` low for 36 cycles. RX word 0xA5.
- Mode 3, `frame_len`=5, `lsb_first`=1, push 0x13 with `miso`=1 -> `mosi` bits 1,1,0,0,1. RX word 0x1F. Bits above 4 read as 0.
- `cs_hold`=1, `cs_sel`=1, push 3 words -> `csb[1]` stays low across all 3 frames, `csb[0]` stays 1. With `cs_hold`=0, a CS-high gap of ≥H appears between frames.
- RX FIFO filled to 16 with `FAW`=4, one more frame -> `rx_ovf` pulses 1 cycle, `rx_level` stays 16, head unchanged.
- Same-cycle `wr`+`tx_flush` -> `tx_level` 0. Reset asserted mid-frame -> `csb` all 1 on the next cycle, `busy` 0, levels 0.
- With `EF_SPI_MC_LOOPBACK_EN` and `loopback`=1, `miso`=0, push 0x3C -> RX word 0x3C.
